sr_phase_sequencer: RTL and testbench

- Sequences the two-phase non-overlapping clocks (clk1/clk2) that drive the latch-based shift register chain.
- Replaces the free-running fixed-pattern generator with a start/busy/done controlled burst engine.
- Phase width and non-overlap gap are programmable, and the block supports counted or continuous shifting.
- Sits between the host-facing control inputs and the latch chain; also emits a sample strobe marking when the chain output is stable.

---
 rtl/sr_phase_sequencer_if.sv | 29 ++
 rtl/sr_phase_sequencer.sv | 132 +++++++++++++
 tb/tb_sr_phase_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_phase_sequencer_if.sv
// Control/status bundle between the host-side controller and the phase sequencer.
// master drives the burst request and configuration; slave returns the phase clocks and status.
interface sr_phase_sequencer_if #(
  parameter int CNT_W = 8,
  parameter int PH_W  = 4
);
  logic             start;
  logic             stop;
  logic             cont;
  logic [CNT_W-1:0] shift_count;
  logic [PH_W-1:0]  ph_width;
  logic [PH_W-1:0]  gap_width;
  logic             clk1;
  logic             clk2;
  logic             busy;
  logic             done;
  logic             sample;
  logic [CNT_W-1:0] shifts;

  modport master (
    output start, stop, cont, shift_count, ph_width, gap_width,
    input  clk1, clk2, busy, done, sample, shifts
  );

  modport slave (
    input  start, stop, cont, shift_count, ph_width, gap_width,
    output clk1, clk2, busy, done, sample, shifts
  );
endinterface

// File: rtl/sr_phase_sequencer.sv
// Burst engine generating non-overlapping two-phase latch enables (clk1/clk2) for the
// latch shift-register chain, with programmable phase/gap widths and counted or continuous mode.
module sr_phase_sequencer #(
  parameter int CNT_W = 8,
  parameter int PH_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  sr_phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, GAP1, PH1, GAP2, PH2} state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  cnt_q, cnt_d;
  logic [PH_W-1:0]  pm1_q, pm1_d;
  logic [PH_W-1:0]  gm1_q, gm1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cont_q, cont_d;
  logic [CNT_W-1:0] shifts_q, shifts_d;
  logic             stop_pend_q, stop_pend_d;
  logic             clk1_q, clk1_d;
  logic             clk2_q, clk2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sample_q, sample_d;

  logic [PH_W-1:0]  start_pm1;
  logic [PH_W-1:0]  start_gm1;
  logic [CNT_W-1:0] shifts_inc;
  logic             burst_end;

  // Widths are held as (width - 1) so a programmed 0 behaves as 1.
  assign start_pm1  = (bus.ph_width  == '0) ? '0 : bus.ph_width  - PH_W'(1);
  assign start_gm1  = (bus.gap_width == '0) ? '0 : bus.gap_width - PH_W'(1);
  assign shifts_inc = (shifts_q == '1) ? shifts_q : shifts_q + CNT_W'(1);
  assign burst_end  = cont_q ? (stop_pend_q | bus.stop) : (shifts_inc == count_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == '0) ? cnt_q : cnt_q - PH_W'(1);
    pm1_d       = pm1_q;
    gm1_d       = gm1_q;
    count_d     = count_q;
    cont_d      = cont_q;
    shifts_d    = shifts_q;
    stop_pend_d = stop_pend_q | (cont_q & bus.stop & (state_q != IDLE));
    done_d      = 1'b0;
    sample_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pm1_d       = start_pm1;
          gm1_d       = start_gm1;
          count_d     = bus.shift_count;
          cont_d      = bus.cont;
          shifts_d    = '0;
          stop_pend_d = 1'b0;
          if (!bus.cont && (bus.shift_count == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = GAP1;
            cnt_d   = start_gm1;
          end
        end
      end
      GAP1: if (cnt_q == '0) begin state_d = PH1;  cnt_d = pm1_q; end
      PH1:  if (cnt_q == '0) begin state_d = GAP2; cnt_d = gm1_q; end
      GAP2: if (cnt_q == '0) begin state_d = PH2;  cnt_d = pm1_q; end
      PH2: begin
        if (cnt_q == '0) begin
          shifts_d = shifts_inc;
          sample_d = 1'b1;
          if (burst_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP1;
            cnt_d   = gm1_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Phase enables are registered decodes of the next state, so they never glitch.
    clk1_d = (state_d == PH1);
    clk2_d = (state_d == PH2);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shifts_q    <= '0;
      stop_pend_q <= 1'b0;
      clk1_q      <= 1'b0;
      clk2_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sample_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shifts_q    <= shifts_d;
      stop_pend_q <= stop_pend_d;
      clk1_q      <= clk1_d;
      clk2_q      <= clk2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sample_q    <= sample_d;
    end
  end

  // Burst configuration is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    pm1_q   <= pm1_d;
    gm1_q   <= gm1_d;
    count_q <= count_d;
    cont_q  <= cont_d;
  end

  assign bus.clk1   = clk1_q;
  assign bus.clk2   = clk2_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sample = sample_q;
  assign bus.shifts = shifts_q;

endmodule

// File: tb/tb_sr_phase_sequencer.sv
// Bench for sr_phase_sequencer: a burst-level reference model predicts every cycle's outputs and
// the sample/done events; a separate monitor compares them, plus a modelled 128-latch chain.
module tb_sr_phase_sequencer;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  sr_phase_sequencer_if #(.CNT_W(8), .PH_W(4)) bif ();

  sr_phase_sequencer #(.CNT_W(8), .PH_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    int cyc;
    bit done;
    bit sample;
    int shifts;
  } ev_t;

  ev_t evq[$];

  // Current burst as seen by the model: start cycle, effective gap/phase widths, shift total.
  bit cur_valid = 0;
  int cur_s0 = 0;
  int cur_g = 1;
  int cur_p = 1;
  int cur_n = 0;
  bit chk_en = 0;

  // Latch chain model driven by the phase clocks.
  bit chain_en = 0;
  bit chain_l[128];
  bit chain_din = 0;
  int chain_j = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: run still active at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Monitor: per-cycle waveform check, invariant check, scoreboard of sample/done events.
  initial begin
    int t, s, r, es;
    bit e1, e2, eb;
    ev_t e;
    bit want;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e1 = 0; e2 = 0; eb = 0; es = 0;
        if (cur_valid) begin
          s = 2 * cur_g + 2 * cur_p;
          t = cyc - cur_s0;
          if (t < cur_n * s) begin
            eb = 1;
            r  = t % s;
            e1 = (r >= cur_g) && (r < cur_g + cur_p);
            e2 = (r >= 2 * cur_g + cur_p);
          end
          es = t / s;
          if (es > cur_n) es = cur_n;
          if (es > 255) es = 255;
        end
        total++;
        if (bif.clk1 !== e1 || bif.clk2 !== e2 || bif.busy !== eb || int'(bif.shifts) != es) begin
          bad++;
          $display("FAIL wave cyc=%0d got clk1=%0b clk2=%0b busy=%0b shifts=%0d want clk1=%0b clk2=%0b busy=%0b shifts=%0d",
                   cyc, bif.clk1, bif.clk2, bif.busy, bif.shifts, e1, e2, eb, es);
        end
        total++;
        if (bif.clk1 && bif.clk2) begin
          bad++;
          $display("FAIL overlap cyc=%0d got clk1=1 clk2=1 want never both high", cyc);
        end
        if (bif.sample || bif.done) begin
          total++;
          if (evq.size() == 0) begin
            bad++;
            $display("FAIL event cyc=%0d got sample=%0b done=%0b shifts=%0d want no event",
                     cyc, bif.sample, bif.done, bif.shifts);
          end else begin
            e = evq.pop_front();
            if (e.cyc != cyc || e.done != bif.done || e.sample != bif.sample || e.shifts != int'(bif.shifts)) begin
              bad++;
              $display("FAIL event got cyc=%0d sample=%0b done=%0b shifts=%0d want cyc=%0d sample=%0b done=%0b shifts=%0d",
                       cyc, bif.sample, bif.done, bif.shifts, e.cyc, e.sample, e.done, e.shifts);
            end
          end
        end
      end
      if (chain_en) begin
        if (bif.sample) begin
          chain_j++;
          // A bit entered during shift k reaches latch 127 at the end of shift k+63 (its 64th shift).
          want = (chain_j >= 64) ? bit'((chain_j - 63) % 2) : 1'b0;
          total++;
          if (chain_l[127] != want) begin
            bad++;
            $display("FAIL chain sample=%0d got %0b want %0b", chain_j, chain_l[127], want);
          end
          chain_din = bit'((chain_j + 1) % 2);
        end
        if (bif.clk1) begin
          chain_l[0] = chain_din;
          for (int i = 2; i < 128; i += 2) chain_l[i] = chain_l[i-1];
        end
        if (bif.clk2) begin
          for (int i = 1; i < 128; i += 2) chain_l[i] = chain_l[i-1];
        end
      end
    end
  end

  task automatic run_burst(input bit c, input int cnt, input int pw, input int gw, input int ts);
    int g, p, s, n, s0;
    g = (gw == 0) ? 1 : gw;
    p = (pw == 0) ? 1 : pw;
    s = 2 * g + 2 * p;
    n = c ? (ts / s + 1) : cnt;
    @(negedge clk);
    bif.start       = 1'b1;
    bif.cont        = c;
    bif.shift_count = 8'(cnt);
    bif.ph_width    = 4'(pw);
    bif.gap_width   = 4'(gw);
    bif.stop        = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    s0 = cyc;
    cur_s0 = s0; cur_g = g; cur_p = p; cur_n = n; cur_valid = 1;
    if (n == 0) evq.push_back('{s0, 1'b1, 1'b0, 0});
    for (int k = 1; k <= n; k++)
      evq.push_back('{s0 + k * s, (k == n), 1'b1, (k > 255) ? 255 : k});
    // Busy cycles: hammer start and config, which must all be ignored.
    while ((cyc - s0) < n * s) begin
      bif.start       = ($urandom_range(0, 3) == 0);
      bif.cont        = 1'($urandom_range(0, 1));
      bif.shift_count = 8'($urandom_range(0, 255));
      bif.ph_width    = 4'($urandom_range(0, 15));
      bif.gap_width   = 4'($urandom_range(0, 15));
      bif.stop        = c ? ((cyc - s0) == ts) : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bif.start = 1'b0;
    bif.stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bif.stop = 1'($urandom_range(0, 1));
    end
    bif.stop = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_ph1();
    bit seen;
    bit stray;
    chk_en = 0;
    @(negedge clk);
    bif.start = 1'b1; bif.cont = 1'b0; bif.shift_count = 8'd3;
    bif.ph_width = 4'd2; bif.gap_width = 4'd1; bif.stop = 1'b0;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bif.clk1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_setup got clk1 never high want clk1 high within 20 cycles");
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bif.clk1 || bif.clk2 || bif.busy || bif.done || bif.sample || bif.shifts != 0) begin
      bad++;
      $display("FAIL async_reset got clk1=%0b clk2=%0b busy=%0b done=%0b sample=%0b shifts=%0d want all 0",
               bif.clk1, bif.clk2, bif.busy, bif.done, bif.sample, bif.shifts);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    evq.delete();
    cur_valid = 0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.done || bif.sample || bif.busy || bif.clk1 || bif.clk2) stray = 1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL reset_abort got activity after aborted burst want idle with no done");
    end
    chk_en = 1;
  endtask

  initial begin
    rst = 1'b1;
    bif.start = 1'b0; bif.stop = 1'b0; bif.cont = 1'b0;
    bif.shift_count = '0; bif.ph_width = '0; bif.gap_width = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bif.clk1 || bif.clk2 || bif.busy || bif.done || bif.sample || bif.shifts != 0) begin
      bad++;
      $display("FAIL reset_state got clk1=%0b clk2=%0b busy=%0b done=%0b sample=%0b shifts=%0d want all 0",
               bif.clk1, bif.clk2, bif.busy, bif.done, bif.sample, bif.shifts);
    end
    rst = 1'b0;
    cur_valid = 0;
    chk_en = 1;
    repeat (3) @(posedge clk);

    run_burst(0, 3, 2, 1, 0);
    run_burst(0, 1, 0, 0, 0);
    run_burst(0, 0, 0, 0, 0);
    run_burst(1, 0, 1, 1, 5);
    run_burst(1, 0, 1, 1, 3);
    run_burst(1, 0, 1, 1, 4);
    reset_mid_ph1();
    run_burst(0, 2, 3, 2, 0);
    run_burst(0, 255, 1, 1, 0);
    run_burst(1, 0, 1, 1, 4 * 300);

    for (int b = 0; b < 25; b++) begin
      if ($urandom_range(0, 2) == 0)
        run_burst(1, 0, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 120));
      else
        run_burst(0, $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 6), 0);
    end

    for (int i = 0; i < 128; i++) chain_l[i] = 1'b0;
    chain_din = 1'b1;
    chain_j = 0;
    chain_en = 1;
    run_burst(0, 128, 1, 1, 0);
    chain_en = 0;

    total++;
    if (evq.size() != 0) begin
      bad++;
      $display("FAIL leftover_events got %0d pending want 0", evq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
